// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the stopwatch seven-segment display.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'hF;

    // Active-low segments, bit0=a .. bit6=g
    function automatic logic [6:0] seg7_lookup(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = seg7_lookup(digit);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode display driver with dead-time, blanking and blinking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 250000,
    parameter int unsigned DEAD_CYC  = 2500,
    parameter int unsigned BLINK_DIV = 100
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blank_mask,
    input  logic [3:0] blink_mask,
    output logic [6:0] led_seg,
    output logic [3:0] AN,
    output logic       blink_phase
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  slot_end_c;
    logic                  blink_wrap_c;
    logic                  dark_c;
    logic [3:0]            digit_c;
    logic [6:0]            seg_c;
    logic [NUM_DIGITS-1:0] an_c;

    // Slot timing, digit select and dark decision for the current cycle
    always_comb begin
        slot_end_c   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        blink_wrap_c = slot_end_c && (blink_cnt == BLINK_W'(BLINK_DIV - 1));
        digit_c      = digit0;
        case (idx)
            2'd1:    digit_c = digit1;
            2'd2:    digit_c = digit2;
            2'd3:    digit_c = digit3;
            default: digit_c = digit0;
        endcase
        dark_c = (scan_cnt < SCAN_W'(DEAD_CYC)) || blank_mask[idx]
                 || (blink_mask[idx] && blink_phase);
        an_c   = ~(NUM_DIGITS'(1) << idx);
    end

    seg7_decode u_decode (
        .digit (digit_c),
        .seg_c (seg_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            AN          <= AN_OFF;
            led_seg     <= SEG_BLANK;
        end else begin
            scan_cnt <= slot_end_c ? '0 : scan_cnt + SCAN_W'(1);
            if (slot_end_c) begin
                idx       <= idx + IDX_W'(1);
                blink_cnt <= blink_wrap_c ? '0 : blink_cnt + BLINK_W'(1);
            end
            if (blink_wrap_c) begin
                blink_phase <= ~blink_phase;
            end
            // Anodes stay off during dead-time so segment changes never ghost
            AN      <= dark_c ? AN_OFF : an_c;
            led_seg <= dark_c ? SEG_BLANK : seg_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based display model.
module tb_seg7_scan_driver;

    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned DEAD_CYC  = 2;
    localparam int unsigned BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0][3:0] dig = '0;
    logic [3:0] blank_mask = '0;
    logic [3:0] blink_mask = '0;
    logic [6:0] led_seg;
    logic [3:0] AN;
    logic       blink_phase;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .DEAD_CYC  (DEAD_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit0      (dig[0]),
        .digit1      (dig[1]),
        .digit2      (dig[2]),
        .digit3      (dig[3]),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .led_seg     (led_seg),
        .AN          (AN),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    endtask

    // The model works from k, the number of non-reset edges since reset.
    task automatic step(input logic r);
        int         sc, id, ph;
        logic       dark;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_ph;
        rst = r;
        sc = k % SCAN_DIV;
        id = (k / SCAN_DIV) % 4;
        ph = (k / (SCAN_DIV * BLINK_DIV)) % 2;
        dark = (sc < DEAD_CYC) || blank_mask[id] || (blink_mask[id] && ph == 1);
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        if (!dark && !r) begin
            exp_an[id] = 1'b0;
            exp_seg    = seg_tab[dig[id]];
        end
        exp_ph = r ? 1'b0 : 1'(((k + 1) / (SCAN_DIV * BLINK_DIV)) % 2);
        @(posedge clk);
        #1;
        chk("an", 32'(AN), 32'(exp_an));
        chk("seg", 32'(led_seg), 32'(exp_seg));
        chk("phase", 32'(blink_phase), 32'(exp_ph));
        chk("an_onehot", 32'($countones(~AN) > 1), 32'd0);
        k = r ? 0 : k + 1;
    endtask

    initial begin
        dig = {4'h1, 4'h2, 4'h3, 4'h4};
        step(1'b1);
        step(1'b1);

        // Reset release: two dead cycles, then digit0 lit
        step(1'b0);
        chk("rel_dead1", 32'(AN), 32'hF);
        step(1'b0);
        chk("rel_dead2", 32'(AN), 32'hF);
        step(1'b0);
        chk("rel_an0", 32'(AN), 32'hE);
        chk("rel_seg0", 32'(led_seg), 32'h19);
        for (int i = 0; i < 61; i++) step(1'b0);

        // Blank the leftmost digit
        blank_mask = 4'b1000;
        dig[3] = 4'h0;
        for (int i = 0; i < 64; i++) step(1'b0);

        // Blink the two right digits
        blank_mask = 4'b0000;
        blink_mask = 4'b0011;
        for (int i = 0; i < 96; i++) step(1'b0);

        // Decode sweep on digit0 with the others blanked
        blink_mask = 4'b0000;
        blank_mask = 4'b1110;
        for (int v = 0; v < 16; v++) begin
            dig[0] = 4'(v);
            for (int i = 0; i < 32; i++) step(1'b0);
        end

        // Mid-slot reset at idx2, scan_cnt 5
        blank_mask = 4'b0000;
        for (int i = 0; i < 64 && (k % 32) != 21; i++) step(1'b0);
        chk("midrst_reach", 32'(k % 32), 32'd21);
        step(1'b1);
        chk("midrst_an", 32'(AN), 32'hF);
        chk("midrst_ph", 32'(blink_phase), 32'd0);
        for (int i = 0; i < 40; i++) step(1'b0);

        // Random digits, masks and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) dig[$urandom_range(0, 3)] = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom);
            step($urandom_range(0, 499) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
